// File: rtl/gbar_pkg.sv
// Shared types and width helpers for the cluster global barrier arbiter.
// Pure declarations: no logic, no latency, no flow control.
package gbar_pkg;

  localparam int GBAR_NUM_REQS     = 4;
  localparam int GBAR_NUM_BARRIERS = 4;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nb_width(input int num_barriers);
    return log2up(num_barriers);
  endfunction

  function automatic int nc_width(input int num_reqs);
    return log2up(num_reqs);
  endfunction

  localparam int GBAR_NB_WIDTH = nb_width(GBAR_NUM_BARRIERS);
  localparam int GBAR_NC_WIDTH = nc_width(GBAR_NUM_REQS);

  // Default-width request view for neighbouring blocks; the top re-derives it from its parameters.
  typedef struct packed {
    logic [GBAR_NB_WIDTH-1:0] id;
    logic [GBAR_NC_WIDTH-1:0] size_m1;
    logic [GBAR_NC_WIDTH-1:0] core_id;
  } gbar_req_t;

  // RELEASE is transient: it is the clear-on-match path back to IDLE.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } gbar_state_e;

endpackage

// File: rtl/gbar_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant, registered pointer (grant+1 on a grant, else hold).
// Grant is one-hot or zero in the same cycle as valid_in; no internal backpressure.
module gbar_rr_arbiter
  import gbar_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = log2up(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  valid_in,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_index,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;

  always_comb begin
    grant_valid  = 1'b0;
    grant_index  = '0;
    grant_onehot = '0;
    idx          = '0;
    // Scan from the farthest offset down so the one closest to the pointer wins.
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (valid_in[idx]) begin
        grant_valid = 1'b1;
        grant_index = idx;
      end
    end
    for (int j = 0; j < N; j++) begin
      grant_onehot[j] = grant_valid && (int'(grant_index) == j);
    end
    ptr_d = grant_valid ? IW'((int'(grant_index) + 1) % N) : ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gbar_arbiter.sv
// Global barrier unit: one accept per cycle, release pulse registered one cycle after the completing accept,
// no response backpressure. GBAR_ARB_PERF_EN adds release and stall counters.
module gbar_arbiter
  import gbar_pkg::*;
#(
  parameter int NUM_REQS     = GBAR_NUM_REQS,
  parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
  parameter int NB_WIDTH     = nb_width(NUM_BARRIERS),
  parameter int NC_WIDTH     = nc_width(NUM_REQS)
`ifdef GBAR_ARB_PERF_EN
  , parameter int PERF_CTR_BITS = 32
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQS-1:0]          req_valid,
  input  logic [NUM_REQS*NB_WIDTH-1:0] req_id,
  input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1,
  input  logic [NUM_REQS*NC_WIDTH-1:0] req_core_id,
  output logic [NUM_REQS-1:0]          req_ready,
  output logic                         rsp_valid,
  output logic [NB_WIDTH-1:0]          rsp_id
`ifdef GBAR_ARB_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]   perf_releases,
  output logic [PERF_CTR_BITS-1:0]     perf_stalls
`endif
);

  localparam int CW = NC_WIDTH + 1;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } req_t;

  logic [NUM_REQS-1:0] arb_vld;
  logic [NUM_REQS-1:0] grant_onehot;
  logic [NC_WIDTH-1:0] grant_index;
  logic                grant_valid;
  req_t                acc;

  gbar_state_e         state_q [NUM_BARRIERS];
  gbar_state_e         state_d [NUM_BARRIERS];
  logic [NUM_REQS-1:0] mask_q  [NUM_BARRIERS];
  logic [NUM_REQS-1:0] mask_d  [NUM_BARRIERS];
  logic [NUM_REQS-1:0] mask_n;
  logic [CW-1:0]       arrived;
  logic                id_ok, new_arrival, complete;
  logic                rsp_valid_q, rsp_valid_d;
  logic [NB_WIDTH-1:0] rsp_id_q, rsp_id_d;

  // No grants while reset is held, even though requesters may keep valid up.
  assign arb_vld = req_valid & {NUM_REQS{reset_n}};

  gbar_rr_arbiter #(
    .N  (NUM_REQS),
    .IW (NC_WIDTH)
  ) u_rr (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (arb_vld),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  assign req_ready = grant_onehot;

  always_comb begin
    acc = '0;
    for (int g = 0; g < NUM_REQS; g++) begin
      if (grant_valid && int'(grant_index) == g) begin
        acc.id      = req_id[g*NB_WIDTH +: NB_WIDTH];
        acc.size_m1 = req_size_m1[g*NC_WIDTH +: NC_WIDTH];
        acc.core_id = req_core_id[g*NC_WIDTH +: NC_WIDTH];
      end
    end
  end

  always_comb begin
    id_ok  = 1'b0;
    mask_n = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (int'(acc.id) == b) begin
        id_ok  = 1'b1;
        mask_n = mask_q[b];
      end
    end
    new_arrival = 1'b0;
    for (int c = 0; c < NUM_REQS; c++) begin
      if (int'(acc.core_id) == c) begin
        new_arrival = !mask_n[c];
        mask_n[c]   = 1'b1;
      end
    end
    arrived = '0;
    for (int c = 0; c < NUM_REQS; c++) begin
      arrived = arrived + CW'(mask_n[c]);
    end
    // A duplicate arrival never completes a barrier, even if sizes disagree.
    complete = grant_valid && id_ok && new_arrival &&
               (arrived == CW'(acc.size_m1) + CW'(1));

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      state_d[b] = state_q[b];
      mask_d[b]  = mask_q[b];
      if (grant_valid && int'(acc.id) == b) begin
        if (complete) begin
          state_d[b] = IDLE;
          mask_d[b]  = '0;
        end else begin
          state_d[b] = COLLECT;
          mask_d[b]  = mask_n;
        end
      end
    end
    rsp_valid_d = complete;
    rsp_id_d    = complete ? acc.id : rsp_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= IDLE;
        mask_q[b]  <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= state_d[b];
        mask_q[b]  <= mask_d[b];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;

  // A barrier wider than the core count can never fill.
  size_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    grant_valid |-> (int'(acc.size_m1) < NUM_REQS));

`ifdef GBAR_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_releases_q, perf_releases_d;
  logic [PERF_CTR_BITS-1:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_releases_d = perf_releases_q + PERF_CTR_BITS'(rsp_valid_q);
    perf_stalls_d   = perf_stalls_q + PERF_CTR_BITS'(|(req_valid & ~grant_onehot));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_releases_q <= '0;
      perf_stalls_q   <= '0;
    end else begin
      perf_releases_q <= perf_releases_d;
      perf_stalls_q   <= perf_stalls_d;
    end
  end

  assign perf_releases = perf_releases_q;
  assign perf_stalls   = perf_stalls_q;
`endif

endmodule

// File: tb/tb_gbar_arbiter.sv
// Bench for gbar_arbiter: directed barrier scenarios then random traffic against a set-based reference model.
module tb_gbar_arbiter;

  localparam int NR   = 4;
  localparam int NBAR = 4;
  localparam int NBW  = 2;
  localparam int NCW  = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*NBW-1:0] req_id;
  logic [NR*NCW-1:0] req_size_m1;
  logic [NR*NCW-1:0] req_core_id;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [NBW-1:0]    rsp_id;

  always #5 clk = ~clk;

  gbar_arbiter #(
    .NUM_REQS     (NR),
    .NUM_BARRIERS (NBAR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_core_id (req_core_id),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id)
  );

  // Requester side: each core holds one pending request until it is accepted.
  bit p_vld [NR];
  int p_id  [NR];
  int p_sz  [NR];
  int p_cid [NR];

  always_comb begin
    req_valid   = '0;
    req_id      = '0;
    req_size_m1 = '0;
    req_core_id = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]              = p_vld[i];
      req_id[i*NBW +: NBW]      = NBW'(p_id[i]);
      req_size_m1[i*NCW +: NCW] = NCW'(p_sz[i]);
      req_core_id[i*NCW +: NCW] = NCW'(p_cid[i]);
    end
  end

  // Reference model: rr pointer plus, per barrier, the set of cores that have arrived.
  int ptr;
  bit arrived [NBAR][NR];
  bit exp_rv;
  int exp_rid;
  int bsize [NBAR];
  bit random_on;
  int rsp_seen;
  int n_tests;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_vld();
    bit r = 1'b0;
    for (int i = 0; i < NR; i++) r |= p_vld[i];
    return r;
  endfunction

  task automatic model_clear();
    ptr    = 0;
    exp_rv = 1'b0;
    for (int b = 0; b < NBAR; b++)
      for (int c = 0; c < NR; c++) arrived[b][c] = 1'b0;
  endtask

  task automatic model_accept(input int g);
    int id, cnt;
    id = p_id[g];
    if (!arrived[id][p_cid[g]]) begin
      arrived[id][p_cid[g]] = 1'b1;
      cnt = 0;
      for (int c = 0; c < NR; c++) cnt += int'(arrived[id][c]);
      if (cnt == p_sz[g] + 1) begin
        for (int c = 0; c < NR; c++) arrived[id][c] = 1'b0;
        exp_rv  = 1'b1;
        exp_rid = id;
      end
    end
  endtask

  task automatic set_req(input int core, input int id, input int sz, input int cid);
    p_vld[core] = 1'b1;
    p_id[core]  = id;
    p_sz[core]  = sz;
    p_cid[core] = cid;
  endtask

  task automatic refill();
    int id;
    for (int i = 0; i < NR; i++) begin
      if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
        id = int'($urandom_range(0, NBAR - 1));
        set_req(i, id, bsize[id],
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NR - 1)) : i);
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model, update requesters after the rising edge.
  task automatic cycle();
    int g;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    for (int i = 0; i < NR; i++)
      if (g < 0 && p_vld[(ptr + i) % NR]) g = (ptr + i) % NR;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("req_ready", req_ready, exp_rdy);
    check_val("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) check_val("rsp_id", rsp_id, exp_rid);
    rsp_seen += int'(rsp_valid);
    exp_rv = 1'b0;
    if (g >= 0) begin
      ptr = (g + 1) % NR;
      model_accept(g);
    end
    @(posedge clk);
    #1;
    if (g >= 0) p_vld[g] = 1'b0;
    if (random_on) refill();
  endtask

  // Run until all requests are accepted and any pulse is checked, plus one quiet cycle.
  task automatic drain();
    int n = 0;
    while ((any_vld() || exp_rv) && n < 64) begin
      cycle();
      n++;
    end
    check_val("drain_done", any_vld() || exp_rv, 0);
    cycle();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_id", rsp_id, 0);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    n_tests   = 0;
    n_fail    = 0;
    rsp_seen  = 0;
    random_on = 1'b0;
    for (int i = 0; i < NR; i++) begin
      p_vld[i] = 1'b0; p_id[i] = 0; p_sz[i] = 0; p_cid[i] = 0;
    end
    model_clear();

    // Reset held with a request pending: nothing granted, nothing released.
    set_req(2, 1, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_id", rsp_id, 0);
    reset_n = 1'b1;
    base = rsp_seen;
    drain();
    check_val("single_rsp_cnt", rsp_seen - base, 1);

    // All four cores join barrier 0 of size 4; grants 0,1,2,3 then one release.
    pulse_reset();
    base = rsp_seen;
    for (int c = 0; c < NR; c++) set_req(c, 0, 3, c);
    drain();
    check_val("four_core_rsp_cnt", rsp_seen - base, 1);

    // Move the pointer to 2, then valid 4'b1011 grants 3,0,1 and leaves it at 2.
    set_req(1, 3, 0, 1);
    drain();
    base = rsp_seen;
    set_req(0, 3, 0, 0);
    set_req(1, 3, 0, 1);
    set_req(3, 3, 0, 3);
    drain();
    check_val("rr_rsp_cnt", rsp_seen - base, 3);
    set_req(0, 3, 0, 0);
    set_req(2, 3, 0, 2);
    drain();

    // Duplicate arrival does not count; a second distinct core completes.
    base = rsp_seen;
    set_req(1, 2, 1, 1);
    drain();
    set_req(1, 2, 1, 1);
    drain();
    check_val("dup_no_rsp", rsp_seen - base, 0);
    set_req(0, 2, 1, 0);
    drain();
    check_val("dup_then_rsp", rsp_seen - base, 1);

    // Interleaved barriers complete independently.
    base = rsp_seen;
    set_req(0, 0, 1, 0); drain();
    set_req(0, 1, 1, 0); drain();
    set_req(1, 1, 1, 1); drain();
    set_req(1, 0, 1, 1); drain();
    check_val("interleave_rsp_cnt", rsp_seen - base, 2);

    // Third arrival to id 2 lands in the cycle of its release pulse and starts a fresh mask.
    base = rsp_seen;
    set_req(0, 2, 1, 0);
    set_req(1, 2, 1, 1);
    set_req(2, 2, 1, 2);
    drain();
    check_val("reuse_rsp_cnt", rsp_seen - base, 1);

    // Reset between arrivals 2 and 3 discards them.
    pulse_reset();
    base = rsp_seen;
    set_req(0, 1, 2, 0); drain();
    set_req(1, 1, 2, 1); drain();
    pulse_reset();
    set_req(2, 1, 2, 2); drain();
    check_val("mid_reset_no_rsp", rsp_seen - base, 0);

    // Random traffic, fixed size per barrier id, occasional foreign core ids.
    pulse_reset();
    for (int b = 0; b < NBAR; b++) bsize[b] = int'($urandom_range(0, NR - 1));
    random_on = 1'b1;
    for (int n = 0; n < 1500; n++) cycle();
    random_on = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
